// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: Booth add/sub + arithmetic shift for
// multiply, or trial subtract + shift for restoring divide.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  op_t              op,
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] opnd,
    output logic [2*WIDTH:0] acc_next
);

    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   opnd_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             qbit;
    logic [2*WIDTH:0] mult_next;
    logic [2*WIDTH:0] div_next;

    // Booth step: the sum is kept one bit wider so the shifted-in sign is exact.
    always_comb begin
        hi_ext   = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        opnd_ext = {opnd[WIDTH-1], opnd};
        case (acc[1:0])
            2'b01:   booth_sum = hi_ext + opnd_ext;
            2'b10:   booth_sum = hi_ext - opnd_ext;
            default: booth_sum = hi_ext;
        endcase
        mult_next = {booth_sum, acc[WIDTH:1]};
    end

    // Restoring divide: acc holds {remainder, quotient/dividend, unused bit}.
    always_comb begin
        shifted = {acc[2*WIDTH:WIDTH+1], acc[WIDTH]};
        diff    = shifted[WIDTH-1:0] - opnd;
        if (shifted >= {1'b0, opnd}) begin
            qbit = 1'b1;
            div_next = {diff, acc[WIDTH-1:1], qbit, 1'b0};
        end else begin
            qbit = 1'b0;
            div_next = {shifted[WIDTH-1:0], acc[WIDTH-1:1], qbit, 1'b0};
        end
    end

    // Operation select.
    always_comb begin
        case (op)
            OP_MULT: acc_next = mult_next;
            OP_DIV:  acc_next = div_next;
            default: acc_next = mult_next;
        endcase
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: WIDTH iterations after the start edge,
// one-cycle data_resultRDY pulse, result/exception held until next completion.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] counter;
    op_t              op;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_next;
    logic [WIDTH-1:0] opnd;
    logic             neg;
    logic             div_zero;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic             start;
    logic             last_iter;
    logic             finish;
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;
    logic             run_flag;
    logic             done_flag;

    // Two's-complement magnitude; the most negative value maps to unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        magnitude = x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_iter = (counter == CNT_W'(WIDTH - 1));
    assign finish    = (state == RUN) && last_iter && !start;

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a start in any state (re)enters RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = start ? RUN : IDLE;
            RUN: begin
                if (start)          state_next = RUN;
                else if (last_iter) state_next = DONE;
                else                state_next = RUN;
            end
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded status outputs.
    always_comb begin
        run_flag  = 1'b0;
        done_flag = 1'b0;
        case (state)
            RUN:     run_flag  = 1'b1;
            DONE:    done_flag = 1'b1;
            default: begin
                run_flag  = 1'b0;
                done_flag = 1'b0;
            end
        endcase
    end

    // Operand capture on start, one datapath iteration per RUN edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter  <= {CNT_W{1'b0}};
            op       <= OP_MULT;
            acc      <= {(2*WIDTH+1){1'b0}};
            opnd     <= {WIDTH{1'b0}};
            neg      <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            counter  <= {CNT_W{1'b0}};
            op       <= ctrl_MULT ? OP_MULT : OP_DIV;
            acc      <= ctrl_MULT ? {{WIDTH{1'b0}}, data_operandB, 1'b0}
                                  : {{WIDTH{1'b0}}, magnitude(data_operandA), 1'b0};
            opnd     <= ctrl_MULT ? data_operandA : magnitude(data_operandB);
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == {WIDTH{1'b0}});
        end else if (state == RUN) begin
            acc     <= acc_next;
            counter <= counter + CNT_W'(1);
        end
    end

    // Final result selection from the last iteration's output.
    always_comb begin
        fin_result = acc_next[WIDTH:1];
        fin_exc    = 1'b0;
        case (op)
            OP_MULT: begin
                fin_result = acc_next[WIDTH:1];
                fin_exc    = !((&acc_next[2*WIDTH:WIDTH]) || (~|acc_next[2*WIDTH:WIDTH]));
            end
            OP_DIV: begin
                if (div_zero) begin
                    fin_result = {WIDTH{1'b0}};
                    fin_exc    = 1'b1;
                end else if (neg) begin
                    fin_result = ~acc_next[WIDTH:1] + {{(WIDTH-1){1'b0}}, 1'b1};
                    fin_exc    = 1'b0;
                end else begin
                    // A positive quotient with the top bit set only arises from MIN / -1.
                    fin_result = acc_next[WIDTH:1];
                    fin_exc    = acc_next[WIDTH];
                end
            end
            default: begin
                fin_result = {WIDTH{1'b0}};
                fin_exc    = 1'b0;
            end
        endcase
    end

    // Result and exception registers, written only on the edge entering DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result    <= {WIDTH{1'b0}};
            exception <= 1'b0;
        end else if (finish) begin
            result    <= fin_result;
            exception <= fin_exc;
        end
    end

    assign data_result    = result;
    assign data_exception = exception;
    assign data_resultRDY = done_flag;
    assign busy           = run_flag;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit with a cycle-level arithmetic reference model.
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks;
    int errors;

    logic        m_busy;
    logic        m_rdy;
    logic [31:0] m_res;
    logic        m_exc;
    logic [31:0] p_res;
    logic        p_exc;
    int          m_left;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected {exception, result} from plain signed arithmetic.
    function automatic logic [32:0] expect_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa;
        int     sb;
        int     q;
        sa = a;
        sb = b;
        if (is_mult) begin
            p = longint'(sa) * longint'(sb);
            return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
        end else if (b == 32'h0) begin
            return {1'b1, 32'h0};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return {1'b1, 32'h8000_0000};
        end else begin
            q = sa / sb;
            return {1'b0, q};
        end
    endfunction

    // Reference model: a start sets up a 32-cycle countdown, completion publishes.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_res  <= 32'h0;
            m_exc  <= 1'b0;
            p_res  <= 32'h0;
            p_exc  <= 1'b0;
            m_left <= 0;
        end else begin
            m_rdy <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                {p_exc, p_res} <= expect_op(ctrl_MULT, data_operandA, data_operandB);
                m_left <= 32;
                m_busy <= 1'b1;
            end else if (m_left == 1) begin
                m_left <= 0;
                m_busy <= 1'b0;
                m_rdy  <= 1'b1;
                m_res  <= p_res;
                m_exc  <= p_exc;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clock);
            chk("busy", {31'h0, busy}, {31'h0, m_busy});
            chk("rdy", {31'h0, data_resultRDY}, {31'h0, m_rdy});
            chk("result", data_result, m_res);
            chk("exception", {31'h0, data_exception}, {31'h0, m_exc});
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc, input string nm);
        int lat;
        start_op(m, d, a, b);
        chk({nm, " busy_after_start"}, {31'h0, busy}, 32'h1);
        wait_rdy(lat);
        chk({nm, " latency"}, lat, 32'd32);
        chk({nm, " result"}, data_result, exp_res);
        chk({nm, " exception"}, {31'h0, data_exception}, {31'h0, exp_exc});
    endtask

    initial begin
        int cnt;
        int lat;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (3) @(negedge clock);
        chk("reset result", data_result, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset rdy", {31'h0, data_resultRDY}, 32'h0);
        chk("reset exception", {31'h0, data_exception}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        run_op(1'b1, 1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf");
        run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0, "mul_max_1");
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_m1");
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2");
        run_op(1'b0, 1'b1, 32'd100,       32'd7,         32'h0000_000E, 1'b0, "div_100_7");
        run_op(1'b0, 1'b1, 32'd5,         32'd0,         32'h0000_0000, 1'b1, "div_by_0");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min_m1");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, "div_min_2");

        // Abort an in-flight MULT with a DIV ten cycles later.
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(negedge clock);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        cnt = 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                cnt++;
                if (lat < 0) lat = i;
            end
        end
        chk("abort rdy_count", cnt, 32'd1);
        chk("abort latency", lat, 32'd32);
        chk("abort result", data_result, 32'd14);

        run_op(1'b1, 1'b1, 32'd6, 32'd2, 32'd12, 1'b0, "both_mult_wins");

        // Asynchronous reset in the middle of a divide.
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (14) @(negedge clock);
        chk("pre_reset busy", {31'h0, busy}, 32'h1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_reset result", data_result, 32'h0);
        chk("async_reset busy", {31'h0, busy}, 32'h0);
        chk("async_reset rdy", {31'h0, data_resultRDY}, 32'h0);
        chk("async_reset exception", {31'h0, data_exception}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) cnt++;
        end
        chk("post_reset rdy_count", cnt, 32'd0);

        run_op(1'b1, 1'b0, 32'd2, 32'd3, 32'd6, 1'b0, "mul_2_3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
